// File: rtl/debounce_pkg.sv
// debounce_pkg
//   Shared definitions for the multi-channel debouncer.
//   - cnt_width(): width needed to hold values 0..n (clog2(n+1), minimum 1)
//   - inactive_level(): synchroniser reset value for a given pin polarity
//   - DEF_STABLE_CYCLES / DEF_LONG_CYCLES: default timing parameters
//   No ports.
package debounce_pkg;

  localparam int unsigned DEF_STABLE_CYCLES = 32'd250000;
  localparam int unsigned DEF_LONG_CYCLES   = 32'd1000000;

  // Number of bits required to represent 0..n; never less than one bit.
  function automatic int unsigned cnt_width(input int unsigned n);
    int unsigned w;
    w = $clog2(n + 32'd1);
    if (w < 32'd1) begin
      w = 32'd1;
    end else begin
      w = w;
    end
    return w;
  endfunction

  // Pin level that means "not pressed" before polarity normalisation.
  function automatic logic inactive_level(input bit active_low);
    return active_low ? 1'b1 : 1'b0;
  endfunction

endpackage

// File: rtl/debounce_channel.sv
// debounce_channel
//   One channel: 2-flop synchroniser, stability counter, debounced level,
//   press/release strobes and (with MULTI_DEBOUNCE_LONG_PRESS_EN defined) a
//   saturating hold counter that raises a one-cycle long-press strobe.
//   Ports:
//     clk        in   system clock
//     rst_n      in   asynchronous active-low reset
//     pin        in   raw asynchronous pin
//     level_o    out  debounced pressed level (1 = pressed)
//     press_o    out  1-cycle strobe on accepted press
//     release_o  out  1-cycle strobe on accepted release
//     long_o     out  1-cycle strobe on long press (0 without the macro)
module debounce_channel
  import debounce_pkg::*;
#(
  parameter int unsigned STABLE_CYCLES = DEF_STABLE_CYCLES,
  parameter int unsigned LONG_CYCLES   = DEF_LONG_CYCLES,
  parameter bit          ACTIVE_LOW    = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic pin,
  output logic level_o,
  output logic press_o,
  output logic release_o,
  output logic long_o
);

  localparam int unsigned       CW       = cnt_width(STABLE_CYCLES);
  localparam logic [CW-1:0]     CNT_LAST = CW'(STABLE_CYCLES - 32'd1);
  localparam logic              INACTIVE = inactive_level(ACTIVE_LOW);

  logic          sync1_q, sync2_q;
  logic          sync_lvl_s;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          level_q, level_d;
  logic          press_q, press_d;
  logic          release_q, release_d;

  // Synchroniser flops; reset to the idle pin level so reset never looks like a press.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= INACTIVE;
      sync2_q <= INACTIVE;
    end else begin
      sync1_q <= pin;
      sync2_q <= sync1_q;
    end
  end

  // Stability counter: any cycle agreeing with the current level restarts the count.
  always_comb begin
    sync_lvl_s = ACTIVE_LOW ? ~sync2_q : sync2_q;
    cnt_d      = cnt_q;
    level_d    = level_q;
    press_d    = 1'b0;
    release_d  = 1'b0;
    if (sync_lvl_s == level_q) begin
      cnt_d = '0;
    end else if (cnt_q == CNT_LAST) begin
      cnt_d     = '0;
      level_d   = sync_lvl_s;
      press_d   = sync_lvl_s;
      release_d = ~sync_lvl_s;
    end else begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  // Counter, level and strobe registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q     <= '0;
      level_q   <= 1'b0;
      press_q   <= 1'b0;
      release_q <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      level_q   <= level_d;
      press_q   <= press_d;
      release_q <= release_d;
    end
  end

  assign level_o   = level_q;
  assign press_o   = press_q;
  assign release_o = release_q;

`ifdef MULTI_DEBOUNCE_LONG_PRESS_EN
  localparam int unsigned   HW        = cnt_width(LONG_CYCLES);
  localparam logic [HW-1:0] HOLD_MAX  = HW'(LONG_CYCLES);
  localparam logic [HW-1:0] HOLD_LAST = HW'(LONG_CYCLES - 32'd1);

  logic [HW-1:0] hold_q, hold_d;
  logic          long_q, long_d;

  // Hold counter runs while pressed and saturates at LONG_CYCLES so the strobe fires once.
  always_comb begin
    hold_d = hold_q;
    long_d = 1'b0;
    if (!level_q) begin
      hold_d = '0;
    end else if (hold_q == HOLD_MAX) begin
      hold_d = hold_q;
    end else begin
      hold_d = hold_q + HW'(1);
      long_d = (hold_q == HOLD_LAST);
    end
  end

  // Hold counter and long-press strobe registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_q <= '0;
      long_q <= 1'b0;
    end else begin
      hold_q <= hold_d;
      long_q <= long_d;
    end
  end

  assign long_o = long_q;
`else
  logic unused_long_s;
  assign unused_long_s = (LONG_CYCLES == 32'd0);
  assign long_o        = 1'b0;
`endif

endmodule

// File: rtl/multi_debounce.sv
// multi_debounce
//   N-channel synchronise-and-debounce front end for buttons and switches.
//   Optional long-press detection is built when MULTI_DEBOUNCE_LONG_PRESS_EN
//   is defined; otherwise btn_long is tied to 0.
//   Ports:
//     clk          in   system clock
//     rst_n        in   asynchronous active-low reset
//     button       in   [NUM_CH] raw asynchronous pins
//     btn_level    out  [NUM_CH] debounced pressed level
//     btn_press    out  [NUM_CH] 1-cycle press strobes
//     btn_release  out  [NUM_CH] 1-cycle release strobes
//     btn_long     out  [NUM_CH] 1-cycle long-press strobes
//     any_press    out  OR of btn_press in the same cycle
module multi_debounce
  import debounce_pkg::*;
#(
  parameter int unsigned NUM_CH        = 32'd4,
  parameter int unsigned STABLE_CYCLES = DEF_STABLE_CYCLES,
  parameter bit          ACTIVE_LOW    = 1'b0,
  parameter int unsigned LONG_CYCLES   = DEF_LONG_CYCLES
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NUM_CH-1:0] button,
  output logic [NUM_CH-1:0] btn_level,
  output logic [NUM_CH-1:0] btn_press,
  output logic [NUM_CH-1:0] btn_release,
  output logic [NUM_CH-1:0] btn_long,
  output logic              any_press
);

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    debounce_channel #(
      .STABLE_CYCLES (STABLE_CYCLES),
      .LONG_CYCLES   (LONG_CYCLES),
      .ACTIVE_LOW    (ACTIVE_LOW)
    ) u_ch (
      .clk       (clk),
      .rst_n     (rst_n),
      .pin       (button[i]),
      .level_o   (btn_level[i]),
      .press_o   (btn_press[i]),
      .release_o (btn_release[i]),
      .long_o    (btn_long[i])
    );
  end

  // OR of registered strobes, so this is glitch-free and aligned with btn_press.
  assign any_press = |btn_press;

endmodule
